// File: rtl/ovl_bus_arbiter_rr.sv
// Round-robin arbiter sharing one address bus among NUM_REQ requesters.
// Each grant is held until done, the request drops, or MAX_HOLD cycles elapse.
module ovl_bus_arbiter_rr #(
  parameter int NUM_REQ   = 4,
  parameter int ADR_WIDTH = 8,
  parameter int MAX_HOLD  = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADR_WIDTH-1:0]   req_adr,
  input  logic                           done,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           bus_grant,
  output logic [ID_W-1:0]                grant_id,
  output logic [ADR_WIDTH-1:0]           current_adr,
  output logic                           timeout
);

  localparam int HC_W = $clog2(MAX_HOLD) + 1;
  localparam int SW   = ID_W + 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_bus_grant;
  logic [ID_W-1:0]      r_grant_id;
  logic [ADR_WIDTH-1:0] r_current_adr;
  logic                 r_timeout;
  logic [HC_W-1:0]      r_hold_cnt;
  logic [ID_W-1:0]      r_last_ptr;

  logic [ADR_WIDTH-1:0] w_adr [NUM_REQ];
  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SW-1:0]        w_shift;
  logic [SW-1:0]        w_sum;
  logic                 w_found;
  logic [ID_W-1:0]      w_winner;
  logic                 w_hold_hit;
  logic                 w_req_drop;
  logic                 w_release;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_adr
      assign w_adr[gi] = req_adr[gi*ADR_WIDTH +: ADR_WIDTH];
    end
  endgenerate

  // Rotate requests so bit 0 is the requester just after the last owner.
  assign w_shift = SW'(r_last_ptr) + SW'(1);
  assign w_req2  = {req, req} >> w_shift;
  assign w_rot   = w_req2[NUM_REQ-1:0];

  always_comb begin
    w_found  = 1'b0;
    w_sum    = '0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = w_shift + SW'(k);
      end
    end
    if (w_sum >= SW'(NUM_REQ)) begin
      w_winner = ID_W'(w_sum - SW'(NUM_REQ));
    end else begin
      w_winner = ID_W'(w_sum);
    end
  end

  assign w_hold_hit = (r_hold_cnt == HC_W'(MAX_HOLD - 1));
  assign w_req_drop = ~req[r_grant_id];
  assign w_release  = done | w_req_drop | w_hold_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_bus_grant   <= 1'b0;
      r_grant_id    <= '0;
      r_current_adr <= '0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
      r_last_ptr    <= ID_W'(NUM_REQ - 1);
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_grant     <= '0;
          r_bus_grant <= 1'b0;
          if (enable && w_found) begin
            r_grant       <= NUM_REQ'(1) << w_winner;
            r_bus_grant   <= 1'b1;
            r_grant_id    <= w_winner;
            r_current_adr <= w_adr[w_winner];
            r_last_ptr    <= w_winner;
            r_hold_cnt    <= '0;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_grant     <= '0;
            r_bus_grant <= 1'b0;
            r_state     <= IDLE;
            // Forced release only counts when nothing else ended the grant.
            r_timeout   <= w_hold_hit & ~done & ~w_req_drop;
          end else begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign bus_grant   = r_bus_grant;
  assign grant_id    = r_grant_id;
  assign current_adr = r_current_adr;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_ovl_bus_arbiter_rr.sv
// Directed bench for ovl_bus_arbiter_rr with hand-computed expectations.
module tb_ovl_bus_arbiter_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req;
  logic [31:0] req_adr;
  logic        done;
  logic [3:0]  grant;
  logic        bus_grant;
  logic [1:0]  grant_id;
  logic [7:0]  current_adr;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  ovl_bus_arbiter_rr #(.NUM_REQ(4), .ADR_WIDTH(8), .MAX_HOLD(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_adr(req_adr),
    .done(done), .grant(grant), .bus_grant(bus_grant), .grant_id(grant_id),
    .current_adr(current_adr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int gcyc;
    int idle_len;
    int ngrants;
    reset = 1'b1; enable = 1'b0; req = '0; req_adr = '0; done = 1'b0;
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_bus", 32'(bus_grant), 0);
    chk("rst_id", 32'(grant_id), 0);
    chk("rst_adr", 32'(current_adr), 0);
    chk("rst_to", 32'(timeout), 0);

    // Single holder runs into the hold limit.
    enable = 1'b1; req = 4'b0001; req_adr[7:0] = 8'h3C;
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_adr", 32'(current_adr), 32'h3C);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_grant) cnt++;
      else break;
    end
    chk("t1_len", 32'(cnt), 16);
    chk("t1_to", 32'(timeout), 1);
    req = '0;
    step();
    chk("t1_to_off", 32'(timeout), 0);

    // All requesting, done every third granted cycle.
    do_reset();
    req = 4'b1111;
    gcyc = 0; idle_len = 0; ngrants = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus_grant) begin
        gcyc++;
        if (gcyc == 1) begin
          chk("t2_id", 32'(grant_id), 32'(ngrants % 4));
          chk("t2_grant", 32'(grant), 32'(1 << (ngrants % 4)));
          if (ngrants > 0) chk("t2_gap", 32'(idle_len), 1);
          ngrants++;
        end
        idle_len = 0;
        done = (gcyc == 3);
      end else begin
        chk("t2_to", 32'(timeout), 0);
        gcyc = 0; idle_len++; done = 1'b0;
        if (ngrants == 5) break;
      end
    end
    chk("t2_count", 32'(ngrants), 5);
    req = '0; done = 1'b0;
    step();

    // Address frozen during a grant (last owner 0, so 2 wins).
    req = 4'b0100; req_adr[23:16] = 8'h55;
    step();
    chk("t3_id", 32'(grant_id), 2);
    chk("t3_adr0", 32'(current_adr), 32'h55);
    req_adr[23:16] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_adr_hold", 32'(current_adr), 32'h55);
    end
    done = 1'b1;
    step();
    chk("t3_rel", 32'(bus_grant), 0);
    chk("t3_adr_keep", 32'(current_adr), 32'h55);
    chk("t3_id_keep", 32'(grant_id), 2);
    done = 1'b0; req = '0;
    step();

    // Request drop releases; pending requester 3 follows after one idle cycle.
    req = 4'b0010;
    step();
    chk("t4_grant1", 32'(grant), 32'h2);
    req = 4'b1010;
    for (int i = 0; i < 3; i++) step();
    chk("t4_still", 32'(grant), 32'h2);
    req = 4'b1000;
    step();
    chk("t4_rel", 32'(bus_grant), 0);
    chk("t4_to", 32'(timeout), 0);
    step();
    chk("t4_grant3", 32'(grant), 32'h8);
    chk("t4_id3", 32'(grant_id), 3);
    done = 1'b1;
    step();
    done = 1'b0; req = '0;
    step();

    // done coincides with the hold limit: no timeout.
    req = 4'b0001;
    step();
    chk("t5_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 15; i++) step();
    chk("t5_still", 32'(bus_grant), 1);
    done = 1'b1;
    step();
    chk("t5_rel", 32'(bus_grant), 0);
    chk("t5_to", 32'(timeout), 0);
    done = 1'b0; req = '0;
    step();

    // Reset during a grant.
    req = 4'b0100; req_adr[23:16] = 8'h77;
    step();
    chk("t6_grant2", 32'(grant), 32'h4);
    step();
    reset = 1'b1;
    step();
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_bus", 32'(bus_grant), 0);
    chk("t6_rst_id", 32'(grant_id), 0);
    chk("t6_rst_adr", 32'(current_adr), 0);
    chk("t6_rst_to", 32'(timeout), 0);
    reset = 1'b0; req = 4'b1111;
    step();
    chk("t6_first", 32'(grant), 32'h1);
    done = 1'b1; req = '0;
    step();
    done = 1'b0;
    step();

    // enable=0 mid-grant: grant finishes, no new grant until re-enabled.
    req = 4'b0010;
    step();
    chk("t7_grant1", 32'(grant), 32'h2);
    enable = 1'b0;
    step();
    step();
    chk("t7_kept", 32'(grant), 32'h2);
    req = 4'b1010; done = 1'b1;
    step();
    chk("t7_rel", 32'(bus_grant), 0);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_blocked", 32'(bus_grant), 0);
    end
    enable = 1'b1;
    step();
    chk("t7_grant3", 32'(grant), 32'h8);
    done = 1'b1; req = '0;
    step();
    done = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
